// File: rtl/paralelo_serial_tx_pkg.sv
// Shared constants for the serial transmit link: symbol width, alignment/idle symbols,
// burst length and FSM state encoding.
package paralelo_serial_tx_pkg;

   localparam int DATA_W    = 8;
   localparam int BIT_CNT_W = $clog2(DATA_W);
   localparam int NUM_COM   = 4;
   localparam int COM_CNT_W = $clog2(NUM_COM + 1);

   localparam logic [DATA_W-1:0] COM = 8'hBC;
   localparam logic [DATA_W-1:0] IDL = 8'h7C;

   localparam logic [0:0] SYNC = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   // Symbol chosen at a byte boundary; sync_req outranks valid data.
   function automatic logic [DATA_W-1:0] select_sym(input logic [0:0]        state,
                                                    input logic              sync_req,
                                                    input logic              valid_in,
                                                    input logic [DATA_W-1:0] data_in);
      if (state == SYNC || sync_req) return COM;
      return valid_in ? data_in : IDL;
   endfunction

endpackage

// File: rtl/paralelo_serial_tx_piso_shift8.sv
// Parallel-in serial-out register: loads a symbol at a boundary and emits it MSB first,
// one bit per clk_32f, with a free-running bit counter that marks byte boundaries.
module piso_shift8
   import paralelo_serial_tx_pkg::*;
(
   input  logic              clk_32f,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] sym,
   output logic              data_out,
   output logic              boundary
);

   logic [DATA_W-1:0]    shreg;
   logic [BIT_CNT_W-1:0] bit_cnt;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         shreg    <= '0;
         bit_cnt  <= '0;
         data_out <= 1'b0;
      end else begin
         bit_cnt <= (bit_cnt == BIT_CNT_W'(DATA_W - 1)) ? '0 : bit_cnt + 1'b1;
         if (load) begin
            shreg    <= sym;
            data_out <= sym[DATA_W-1];
         end else begin
            // shreg[DATA_W-2] is the next bit once the previous one has left on data_out
            shreg    <= {shreg[DATA_W-2:0], 1'b0};
            data_out <= shreg[DATA_W-2];
         end
      end
   end

   assign boundary = (bit_cnt == '0);

endmodule

// File: rtl/paralelo_serial_tx.sv
// Serial link transmitter: COM alignment burst after reset or on request, then one data
// byte or IDL symbol per 8-bit slot, shifted out MSB first.
module paralelo_serial_tx
   import paralelo_serial_tx_pkg::*;
(
   input  logic              clk_32f,
   input  logic              reset,
   input  logic [DATA_W-1:0] data_in,
   input  logic              valid_in,
   input  logic              sync_req,
   output logic              data_out,
   output logic              ready,
   output logic              active,
   output logic              byte_strobe
);

   logic [0:0]           state;
   logic [COM_CNT_W-1:0] com_cnt;
   logic                 boundary;
   logic [DATA_W-1:0]    sym;

   assign sym = select_sym(state, sync_req, valid_in, data_in);

   piso_shift8 u_piso (
      .clk_32f  (clk_32f),
      .reset    (reset),
      .load     (boundary),
      .sym      (sym),
      .data_out (data_out),
      .boundary (boundary)
   );

   always_ff @(posedge clk_32f) begin
      if (!reset) begin
         state       <= SYNC;
         com_cnt     <= '0;
         byte_strobe <= 1'b0;
      end else begin
         byte_strobe <= boundary;
         if (boundary) begin
            if (state == SYNC) begin
               if (com_cnt >= COM_CNT_W'(NUM_COM - 1)) begin
                  com_cnt <= '0;
                  state   <= RUN;
               end else begin
                  com_cnt <= com_cnt + 1'b1;
               end
            end else if (sync_req) begin
               // The COM loaded on this edge is the first of the new burst.
               com_cnt <= COM_CNT_W'(1);
               state   <= SYNC;
            end
         end
      end
   end

   assign active = (state == RUN);
   assign ready  = active && boundary;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench: the driver pushes each expected symbol as it is issued, and a monitor
// reassembles byte_strobe-framed symbols from data_out and compares them in order.
module tb_paralelo_serial_tx;

   logic       clk_32f = 1'b0;
   logic       reset;
   logic [7:0] data_in;
   logic       valid_in;
   logic       sync_req;
   logic       data_out;
   logic       ready;
   logic       active;
   logic       byte_strobe;

   localparam logic [7:0] COM_S = 8'hBC;
   localparam logic [7:0] IDL_S = 8'h7C;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q[$];

   paralelo_serial_tx dut (
      .clk_32f     (clk_32f),
      .reset       (reset),
      .data_in     (data_in),
      .valid_in    (valid_in),
      .sync_req    (sync_req),
      .data_out    (data_out),
      .ready       (ready),
      .active      (active),
      .byte_strobe (byte_strobe)
   );

   always #5 clk_32f = ~clk_32f;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Called at the negedge before a boundary edge; returns at the negedge before the next one.
   task automatic slot(input logic s, input logic v, input logic [7:0] d,
                       input logic [7:0] exp_sym, input logic exp_rdy, input int exp_act);
      check("ready_at_boundary", ready, exp_rdy);
      sync_req = s;
      valid_in = v;
      data_in  = d;
      exp_q.push_back(exp_sym);
      @(negedge clk_32f);
      check("byte_strobe", byte_strobe, 1);
      check("ready_mid_symbol", ready, 0);
      if (exp_act >= 0) check("active", active, exp_act[0]);
      repeat (7) @(negedge clk_32f);
   endtask

   task automatic com_burst(input logic v, input logic [7:0] d, input int n);
      for (int i = 0; i < n; i++)
         slot(1'b0, v, d, COM_S, 1'b0, (i == n - 1) ? -1 : 0);
   endtask

   // Monitor: acts as the aligned receiver on the serial line.
   initial begin
      logic [7:0] shift_v;
      int         nbits;
      bit         collecting;
      collecting = 0;
      nbits      = 0;
      shift_v    = '0;
      forever begin
         @(negedge clk_32f);
         if (reset !== 1'b1) begin
            collecting = 0;
            nbits      = 0;
         end else begin
            if (byte_strobe) begin
               if (collecting) check("strobe_frame", nbits, 8);
               shift_v    = {7'b0, data_out};
               nbits      = 1;
               collecting = 1;
            end else if (collecting) begin
               shift_v = {shift_v[6:0], data_out};
               nbits++;
            end
            if (collecting && nbits == 8) begin
               if (exp_q.size() == 0) check("unexpected_symbol", {24'b0, shift_v}, 32'h100);
               else                   check("symbol", shift_v, exp_q.pop_front());
               collecting = 0;
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] rd;
      logic       rv;
      reset    = 1'b0;
      data_in  = 8'h00;
      valid_in = 1'b0;
      sync_req = 1'b0;

      // 1: reset state and alignment burst
      repeat (64) @(negedge clk_32f);
      check("rst_data_out", data_out, 0);
      check("rst_ready", ready, 0);
      check("rst_active", active, 0);
      check("rst_byte_strobe", byte_strobe, 0);
      reset = 1'b1;
      com_burst(1'b0, 8'h00, 4);

      // 2: valid data
      slot(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1, 1);
      slot(1'b0, 1'b1, 8'hEE, 8'hEE, 1'b1, 1);
      // 3: invalid slot sends IDL, data ignored
      slot(1'b0, 1'b0, 8'h55, IDL_S, 1'b1, 1);

      // 4: sync_req wins over valid data; upstream holds 8'hDD through the burst
      slot(1'b1, 1'b1, 8'hDD, COM_S, 1'b1, 0);
      com_burst(1'b1, 8'hDD, 3);
      slot(1'b0, 1'b1, 8'hDD, 8'hDD, 1'b1, 1);

      // 5: reset mid-byte of 8'hCC at bit_cnt==3
      check("ready_before_cc", ready, 1);
      valid_in = 1'b1;
      data_in  = 8'hCC;
      exp_q.push_back(8'hCC);
      repeat (3) @(negedge clk_32f);
      reset = 1'b0;
      @(negedge clk_32f);
      check("midrst_data_out", data_out, 0);
      check("midrst_active", active, 0);
      check("midrst_ready", ready, 0);
      check("midrst_byte_strobe", byte_strobe, 0);
      exp_q.delete();
      valid_in = 1'b0;
      repeat (3) @(negedge clk_32f);
      reset = 1'b1;
      com_burst(1'b0, 8'h00, 4);
      slot(1'b0, 1'b1, 8'hA5, 8'hA5, 1'b1, 1);

      // 6: random bytes with random valid
      for (int i = 0; i < 20; i++) begin
         rd = 8'($urandom_range(0, 255));
         rv = 1'($urandom_range(0, 1));
         slot(1'b0, rv, rd, rv ? rd : IDL_S, 1'b1, 1);
      end

      valid_in = 1'b0;
      for (int i = 0; i < 24 && exp_q.size() != 0; i++) @(negedge clk_32f);
      check("scoreboard_drain", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
